// File: rtl/lcd_bus_pkg.sv
// lcd_bus_pkg: FSM state codes and FIFO entry layout shared by the
// LCD bus writer and its input FIFO.
package lcd_bus_pkg;

    localparam int LCD_DATA_W = 16;

    localparam logic [2:0] ST_INIT = 3'd0;
    localparam logic [2:0] ST_IDLE = 3'd1;
    localparam logic [2:0] ST_LOAD = 3'd2;
    localparam logic [2:0] ST_LOW  = 3'd3;
    localparam logic [2:0] ST_HIGH = 3'd4;

    typedef struct packed {
        logic                  rs;
        logic [LCD_DATA_W-1:0] data;
    } lcd_entry_t;

endpackage

// File: rtl/lcd_bus_fifo.sv
// lcd_bus_fifo: synchronous FIFO of {rs, data} entries.
// Show-ahead read port; full blocks push even when popping.
module lcd_bus_fifo #(
    parameter int W     = 17,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    output logic [W-1:0]  pop_data,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // storage array, written on accepted pushes only
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // pointers and occupancy; push+pop together leaves count unchanged
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/lcd_bus_writer.sv
// lcd_bus_writer: 8080-style LCD write engine with panel power-up reset.
// LCD_BUS_WRITER_FIFO_EN selects the deep FIFO over a 1-entry register.
module lcd_bus_writer #(
    parameter int DATA_W         = 16,
    parameter int WR_LOW_CYCLES  = 2,
    parameter int WR_HIGH_CYCLES = 2,
    parameter int FIFO_DEPTH     = 16,
    parameter int RESET_CYCLES   = 1024
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_rs,
    input  logic [DATA_W-1:0] in_data,
    input  logic              lcd_enable,
    output logic              busy,
    output logic              cs_n,
    output logic              rs,
    output logic              wr_n,
    output logic              rd_n,
    output logic [DATA_W-1:0] lcd_data,
    output logic              lcd_on,
    output logic              lcd_reset_n
);

    import lcd_bus_pkg::*;

    localparam int PH_MAX = (WR_LOW_CYCLES > WR_HIGH_CYCLES) ?
                            WR_LOW_CYCLES : WR_HIGH_CYCLES;
    localparam int PH_W   = $clog2(PH_MAX + 1);
    localparam int RC_W   = $clog2(RESET_CYCLES + 1);
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int EW     = DATA_W + 1;

    logic [2:0]       state;
    logic [2:0]       nxt;
    logic [PH_W-1:0]  phase_cnt;
    logic             ph_done;
    logic [RC_W-1:0]  rst_cnt;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_pop;
    logic [CNT_W-1:0] fifo_count;
    logic [EW-1:0]    head;

    assign fifo_pop = (state == ST_LOAD);
    assign in_ready = !fifo_full;
    assign rd_n     = 1'b1;
    assign busy     = (fifo_count != '0) ||
                      ((state != ST_INIT) && (state != ST_IDLE));

`ifdef LCD_BUS_WRITER_FIFO_EN
    lcd_bus_fifo #(
        .W     (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (in_valid),
        .push_data ({in_rs, in_data}),
        .pop       (fifo_pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );
`else
    logic          hold_valid;
    logic [EW-1:0] hold_word;

    // single holding register: filled on accept, drained in LOAD
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_valid <= 1'b0;
            hold_word  <= '0;
        end else begin
            if (fifo_pop) begin
                hold_valid <= 1'b0;
            end
            if (in_valid && !hold_valid) begin
                hold_valid <= 1'b1;
                hold_word  <= {in_rs, in_data};
            end
        end
    end

    assign fifo_full  = hold_valid;
    assign fifo_empty = !hold_valid;
    assign fifo_count = CNT_W'(hold_valid);
    assign head       = hold_word;
`endif

    // power-up: keep the panel in reset for RESET_CYCLES clocks
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rst_cnt     <= '0;
            lcd_reset_n <= 1'b0;
        end else if (!lcd_reset_n) begin
            rst_cnt <= rst_cnt + 1'b1;
            if (rst_cnt == RC_W'(RESET_CYCLES - 1)) begin
                lcd_reset_n <= 1'b1;
            end
        end
    end

    // end of the current strobe phase
    always_comb begin
        ph_done = 1'b0;
        if (state == ST_LOW) begin
            ph_done = (phase_cnt == PH_W'(WR_LOW_CYCLES - 1));
        end else begin
            ph_done = (phase_cnt == PH_W'(WR_HIGH_CYCLES - 1));
        end
    end

    // next-state decode
    always_comb begin
        nxt = state;
        unique case (state)
            ST_INIT: if (lcd_reset_n) nxt = ST_IDLE;
            ST_IDLE: if (!fifo_empty) nxt = ST_LOAD;
            ST_LOAD: nxt = ST_LOW;
            ST_LOW:  if (ph_done) nxt = ST_HIGH;
            ST_HIGH: if (ph_done) nxt = fifo_empty ? ST_IDLE : ST_LOAD;
            default: nxt = ST_INIT;
        endcase
    end

    // state, phase timer and bus outputs, registered against next state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_INIT;
            phase_cnt <= '0;
            cs_n      <= 1'b1;
            wr_n      <= 1'b1;
            rs        <= 1'b1;
            lcd_data  <= '0;
        end else begin
            state <= nxt;
            if (nxt != state) begin
                phase_cnt <= '0;
            end else if (phase_cnt != PH_W'(PH_MAX)) begin
                phase_cnt <= phase_cnt + 1'b1;
            end
            cs_n <= (nxt == ST_INIT) || (nxt == ST_IDLE);
            wr_n <= (nxt != ST_LOW);
            if (nxt == ST_LOAD) begin
                rs       <= head[DATA_W];
                lcd_data <= head[DATA_W-1:0];
            end
        end
    end

    // display enable follows software with one flop, independent of FSM
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lcd_on <= 1'b0;
        end else begin
            lcd_on <= lcd_enable;
        end
    end

endmodule
